// File: rtl/multiplicador_seq_pkg.sv
// Shared types and helpers for the sequential shift-and-add multiplier.
`timescale 1ns/1ps
package multiplicador_pkg;

  typedef enum logic [1:0] {
    IDLE = 2'b00,
    CALC = 2'b01,
    DONE = 2'b10
  } state_t;

  // Iteration counter width; never below one bit so the counter stays declarable.
  function automatic int cnt_width(input int bits);
    return (bits < 2) ? 1 : $clog2(bits);
  endfunction

endpackage

// File: rtl/multiplicador_seq_if.sv
// Start/done handshake and operand/result bus of the multiplier.
`timescale 1ns/1ps
interface multiplicador_seq_if #(
  parameter int BIT = 4
);
  logic               start;
  logic [BIT-1:0]     num1;
  logic [BIT-1:0]     num2;
  logic               busy;
  logic               done;
  logic [2*BIT-1:0]   Result;
  logic               OFLOW;

  modport master (
    output start, num1, num2,
    input  busy, done, Result, OFLOW
  );

  modport slave (
    input  start, num1, num2,
    output busy, done, Result, OFLOW
  );
endinterface

// File: rtl/multiplicador_seq_step.sv
// One shift-and-add iteration: conditional accumulate, then shift both operands.
`timescale 1ns/1ps
module multiplicador_step #(
  parameter int BIT = 4
) (
  input  logic [2*BIT-1:0] acc,
  input  logic [2*BIT-1:0] mcand,
  input  logic [BIT-1:0]   mplier,
  output logic [2*BIT-1:0] acc_next,
  output logic [2*BIT-1:0] mcand_next,
  output logic [BIT-1:0]   mplier_next
);

  assign acc_next    = mplier[0] ? (acc + mcand) : acc;
  assign mcand_next  = mcand << 1;
  assign mplier_next = mplier >> 1;

endmodule

// File: rtl/multiplicador_seq.sv
// Sequential unsigned multiplier: one multiplier bit per clock, BIT cycles per product.
`timescale 1ns/1ps
module multiplicador_seq
  import multiplicador_pkg::*;
#(
  parameter int BIT = 4
) (
  input  logic                clk,
  input  logic                rst_n,
  multiplicador_seq_if.slave  bus
);

  localparam int CW = cnt_width(BIT);

  state_t            state_reg;
  logic [2*BIT-1:0]  acc_reg;
  logic [2*BIT-1:0]  mcand_reg;
  logic [BIT-1:0]    mplier_reg;
  logic [CW-1:0]     cnt_reg;
  logic              busy_reg;
  logic              done_reg;
  logic [2*BIT-1:0]  result_reg;
  logic              oflow_reg;

  logic [2*BIT-1:0]  acc_next;
  logic [2*BIT-1:0]  mcand_next;
  logic [BIT-1:0]    mplier_next;

  multiplicador_step #(.BIT(BIT)) u_step (
    .acc         (acc_reg),
    .mcand       (mcand_reg),
    .mplier      (mplier_reg),
    .acc_next    (acc_next),
    .mcand_next  (mcand_next),
    .mplier_next (mplier_next)
  );

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_reg  <= IDLE;
      acc_reg    <= '0;
      mcand_reg  <= '0;
      mplier_reg <= '0;
      cnt_reg    <= '0;
      busy_reg   <= 1'b0;
      done_reg   <= 1'b0;
      result_reg <= '0;
      oflow_reg  <= 1'b0;
    end else begin
      case (state_reg)
        IDLE: begin
          done_reg <= 1'b0;
          if (bus.start) begin
            mcand_reg  <= {{BIT{1'b0}}, bus.num1};
            mplier_reg <= bus.num2;
            acc_reg    <= '0;
            cnt_reg    <= '0;
            busy_reg   <= 1'b1;
            state_reg  <= CALC;
          end
        end
        CALC: begin
          acc_reg    <= acc_next;
          mcand_reg  <= mcand_next;
          mplier_reg <= mplier_next;
          cnt_reg    <= cnt_reg + 1'b1;
          // Outputs are loaded only from the final sum, never from partial ones.
          if (cnt_reg == CW'(BIT - 1)) begin
            result_reg <= acc_next;
            oflow_reg  <= |acc_next[2*BIT-1:BIT];
            done_reg   <= 1'b1;
            state_reg  <= DONE;
          end
        end
        DONE: begin
          done_reg  <= 1'b0;
          busy_reg  <= 1'b0;
          state_reg <= IDLE;
        end
        default: begin
          done_reg  <= 1'b0;
          busy_reg  <= 1'b0;
          state_reg <= IDLE;
        end
      endcase
    end
  end

  assign bus.busy   = busy_reg;
  assign bus.done   = done_reg;
  assign bus.Result = result_reg;
  assign bus.OFLOW  = oflow_reg;

endmodule

// File: tb/tb_multiplicador_seq.sv
// Randomized and directed check of multiplicador_seq against a plain-arithmetic product model.
`timescale 1ns/1ps
module tb_multiplicador_seq;

  localparam int BIT = 4;
  localparam int W   = 2 * BIT;

  logic clk = 1'b0;
  logic rst_n;

  always #5 clk = ~clk;

  multiplicador_seq_if #(.BIT(BIT)) bus ();

  multiplicador_seq #(.BIT(BIT)) dut (
    .clk   (clk),
    .rst_n (rst_n),
    .bus   (bus)
  );

  int unsigned n_vec = 0;
  int unsigned n_bad = 0;
  logic [W-1:0] last_res;
  logic         last_ofl;

  task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_vec++;
    if (got !== exp) begin
      n_bad++;
      $display("FAIL %s: got %0h, expected %0h", tag, got, exp);
    end
  endtask

  // One multiplication starting right after a rising edge; returns 1ns after the
  // edge that takes the block back to IDLE, so consecutive calls run back-to-back.
  task automatic run_mult(input logic [BIT-1:0] a, input logic [BIT-1:0] b, input bit disturb);
    int unsigned prod;
    bit          ofl;
    prod = int'(a) * int'(b);
    ofl  = (prod > (2**BIT - 1));
    bus.num1  = a;
    bus.num2  = b;
    bus.start = 1'b1;
    @(posedge clk); #1;
    bus.start = disturb;
    if (disturb) begin
      bus.num1 = BIT'($urandom);
      bus.num2 = BIT'($urandom);
    end
    chk("busy_after_accept", 64'(bus.busy), 64'(1));
    for (int k = 1; k <= BIT + 1; k++) begin
      @(posedge clk); #1;
      chk("done_timing", 64'(bus.done), 64'(k == BIT));
      chk("busy_timing", 64'(bus.busy), 64'(k <= BIT));
      if (k < BIT) begin
        chk("result_hold", 64'(bus.Result), 64'(last_res));
        chk("oflow_hold",  64'(bus.OFLOW),  64'(last_ofl));
      end
      if (k == BIT) begin
        chk("result", 64'(bus.Result), 64'(prod));
        chk("oflow",  64'(bus.OFLOW),  64'(ofl));
        last_res = W'(prod);
        last_ofl = ofl;
      end
    end
    bus.start = 1'b0;
    $display("mult %0d x %0d -> Result=%0d OFLOW=%0b (expected %0d/%0b)%s",
             a, b, bus.Result, bus.OFLOW, prod, ofl, disturb ? " [disturbed]" : "");
  endtask

  initial begin
    rst_n     = 1'b0;
    bus.start = 1'b1;
    bus.num1  = 4'hF;
    bus.num2  = 4'hF;
    last_res  = '0;
    last_ofl  = 1'b0;

    for (int i = 0; i < 3; i++) begin
      @(posedge clk); #1;
      chk("rst_busy",   64'(bus.busy),   64'(0));
      chk("rst_done",   64'(bus.done),   64'(0));
      chk("rst_result", 64'(bus.Result), 64'(0));
      chk("rst_oflow",  64'(bus.OFLOW),  64'(0));
    end
    @(negedge clk);
    rst_n     = 1'b1;
    bus.start = 1'b0;
    @(posedge clk); #1;

    run_mult(4'b0100, 4'b0010, 1'b0);
    run_mult(4'hF, 4'hF, 1'b0);
    run_mult(4'h4, 4'h4, 1'b0);
    run_mult(4'h0, 4'hB, 1'b0);
    run_mult(4'h1, 4'hF, 1'b0);
    run_mult(4'h5, 4'h7, 1'b1);
    run_mult(4'h3, 4'h9, 1'b1);

    // Abort mid-calculation: outputs clear without waiting for an edge.
    bus.num1  = 4'h9;
    bus.num2  = 4'h7;
    bus.start = 1'b1;
    @(posedge clk); #1;
    bus.start = 1'b0;
    @(posedge clk); #1;
    @(posedge clk); #3;
    rst_n = 1'b0;
    #1;
    chk("async_rst_busy",   64'(bus.busy),   64'(0));
    chk("async_rst_done",   64'(bus.done),   64'(0));
    chk("async_rst_result", 64'(bus.Result), 64'(0));
    chk("async_rst_oflow",  64'(bus.OFLOW),  64'(0));
    last_res = '0;
    last_ofl = 1'b0;
    @(negedge clk);
    rst_n = 1'b1;
    for (int k = 0; k < BIT + 3; k++) begin
      @(posedge clk); #1;
      chk("no_done_after_abort", 64'(bus.done), 64'(0));
      chk("idle_after_abort",    64'(bus.busy), 64'(0));
    end
    $display("abort mid-CALC -> Result=%0d busy=%0b", bus.Result, bus.busy);

    for (int i = 0; i < 24; i++) begin
      run_mult(BIT'($urandom), BIT'($urandom), 1'($urandom));
    end

    for (int a = 0; a < 2**BIT; a++) begin
      for (int b = 0; b < 2**BIT; b++) begin
        run_mult(BIT'(a), BIT'(b), 1'b0);
      end
    end

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
    $finish;
  end

endmodule

// File: doc/multiplicador_seq.md
Name: multiplicador_seq

Overview:
- Sequential unsigned shift-and-add multiplier: BIT-bit by BIT-bit operands produce a 2*BIT-bit product.
- Includes an overflow flag that is set when the product does not fit in BIT bits.
- Used as a shared arithmetic block, started with a start/done handshake.
- Computes one multiplier bit per clock, so a result takes BIT cycles.

Parameters:
- BIT, 4, operand width in bits; legal range 2..32.

Ports:
- clk, input, 1, single system clock; all state updates on the rising edge.
- rst_n, input, 1, asynchronous active-low reset.
- start, input, 1, request to begin a multiplication; sampled only in IDLE.
- num1, input, BIT, unsigned multiplicand; captured on the accepted start edge.
- num2, input, BIT, unsigned multiplier; captured on the accepted start edge.
- busy, output, 1, high while in CALC or DONE.
- done, output, 1, one-cycle pulse: Result and OFLOW are valid and newly updated.
- Result, output, 2*BIT, unsigned product num1*num2.
- OFLOW, output, 1, set when Result[2*BIT-1:BIT] is non-zero.

Behaviour:
- Reset:
  - rst_n low, asynchronous: state=IDLE; busy=0, done=0, Result=0, OFLOW=0.
  - Internal accumulator, operand registers and bit counter cleared.
  - Reset mid-operation aborts the computation; no done is produced.
- States:
  - IDLE:
    - busy=0.
    - start=1 at an edge: latch num1 into mcand (zero-extended to 2*BIT), num2 into mplier, acc=0, cnt=0; go to CALC.
  - CALC:
    - Each edge: if mplier[0], acc += mcand; then mcand <<= 1, mplier >>= 1, cnt++.
    - After the BIT-th CALC edge (cnt==BIT-1 at that edge), load Result=final acc and OFLOW=|final acc[2*BIT-1:BIT]; go to DONE.
  - DONE:
    - done=1 for exactly one cycle; next edge returns to IDLE.
- Latency: start accepted at edge E0 -> done high during the cycle after edge E0+BIT; next start may be accepted at edge E0+BIT+2.
- start while busy (CALC or DONE) is ignored; no queuing.
- num1/num2 changes after the capture edge do not affect the operation in flight.
- Result and OFLOW hold their last values until the next completion or reset. They are never updated with partial sums.
- Arithmetic:
  - Unsigned throughout; no truncation inside the 2*BIT accumulator; cannot overflow 2*BIT bits.
  - Max case: (2^BIT-1)^2.
- Zero operands still take the full BIT cycles (fixed latency).
- done and busy are registered outputs, with no combinational path from inputs.

Decomposition:
- Package multiplicador_pkg:
  - State enum typedef (IDLE, CALC, DONE), 2-bit encoding.
  - Counter-width helper function, $clog2(BIT).
- One sub-module, multiplicador_step: combinational, one shift-add iteration.
  - Inputs: acc, mcand, mplier.
  - Outputs: next acc, mcand, mplier.
- Top holds the FSM, counter and output registers.

Test Plan:
- Reset: hold rst_n=0 with start=1 -> busy=0, done=0, Result=8'h00, OFLOW=0. Assert rst_n low mid-CALC -> outputs return to 0 immediately (asynchronously) and no done pulse follows.
- Basic case: num1=4'b0100, num2=4'b0010, start pulse -> done 4 cycles after the accepted edge; Result=8'b0000_1000, OFLOW=0.
- Overflow: num1=4'hF, num2=4'hF -> Result=8'hE1, OFLOW=1. Also num1=4'h4, num2=4'h4 -> Result=8'h10, OFLOW=1.
- Zero and one operands: 0 x 4'hB -> Result=0, OFLOW=0, still 4-cycle latency. 1 x 4'hF -> Result=8'h0F, OFLOW=0.
- Start while busy: second start with different operands during CALC is ignored; first product is reported. Changing num1/num2 mid-CALC does not alter the result.
- Exhaustive sweep: all 256 operand pairs back-to-back -> Result==num1*num2 and OFLOW==(product>15) at every done; done pulse is exactly one cycle wide.
